// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared CPU definitions for redirect sequencing: state and cause encodings,
// and the default interrupt vector.
package pc_redirect_ctrl_pkg;

    localparam logic [31:0] INT_VECTOR_DEFAULT = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Redirect cause as seen by debug tooling
    typedef enum logic [1:0] {
        CAUSE_JUMP = 2'd0,
        CAUSE_RETI = 2'd1,
        CAUSE_INT  = 2'd2
    } cause_t;

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Control-flow redirect sequencer: jumps, RETI, HALT and interrupt entry,
// driving one valid/ready redirect request to fetch.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]        INT_VECTOR = ADDR_W'(INT_VECTOR_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              ex_halt,
    input  logic              ex_reti,
    input  logic [ADDR_W-1:0] ex_next_pc,
    input  logic              int_req,
    input  logic              redir_ready,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_addr,
    output logic              flush,
    output logic              ex_stall,
    output logic              halted,
    output logic              int_active,
    output logic [ADDR_W-1:0] epc,
    output logic [31:0]       redirect_count
);

    state_t            state, state_n;
    logic              halt_after, halt_after_n;
    logic              redir_valid_n, flush_n, halted_n, int_active_n;
    logic [ADDR_W-1:0] redir_addr_n, epc_n;
    logic [31:0]       redirect_count_n;

    assign ex_stall = (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_RUN;
            halt_after     <= 1'b0;
            redir_valid    <= 1'b0;
            redir_addr     <= '0;
            flush          <= 1'b0;
            halted         <= 1'b0;
            int_active     <= 1'b0;
            epc            <= '0;
            redirect_count <= '0;
        end else begin
            state          <= state_n;
            halt_after     <= halt_after_n;
            redir_valid    <= redir_valid_n;
            redir_addr     <= redir_addr_n;
            flush          <= flush_n;
            halted         <= halted_n;
            int_active     <= int_active_n;
            epc            <= epc_n;
            redirect_count <= redirect_count_n;
        end
    end

    always_comb begin
        state_n          = state;
        halt_after_n     = halt_after;
        redir_valid_n    = redir_valid;
        redir_addr_n     = redir_addr;
        flush_n          = flush;
        halted_n         = halted;
        int_active_n     = int_active;
        epc_n            = epc;
        redirect_count_n = redirect_count;

        case (state)
            ST_RUN: begin
                redir_valid_n = 1'b0;
                flush_n       = 1'b0;
                if (ex_valid && ex_reti) begin
                    redir_addr_n  = epc;
                    int_active_n  = 1'b0;
                    redir_valid_n = 1'b1;
                    flush_n       = 1'b1;
                    state_n       = ST_PEND;
                end else if (ex_valid && jump_valid) begin
                    redir_addr_n  = jump_addr;
                    halt_after_n  = ex_halt;
                    redir_valid_n = 1'b1;
                    flush_n       = 1'b1;
                    state_n       = ST_PEND;
                end else if (int_req && !int_active) begin
                    redir_addr_n  = INT_VECTOR;
                    epc_n         = ex_next_pc;
                    int_active_n  = 1'b1;
                    redir_valid_n = 1'b1;
                    flush_n       = 1'b1;
                    state_n       = ST_PEND;
                end
            end
            ST_PEND: begin
                if (redir_ready) begin
                    redirect_count_n = redirect_count + 32'd1;
                    redir_valid_n    = 1'b0;
                    halt_after_n     = 1'b0;
                    if (halt_after) begin
                        state_n  = ST_HALTED;
                        halted_n = 1'b1;
                        flush_n  = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                        flush_n = 1'b0;
                    end
                end
            end
            ST_HALTED: begin
                // redir_addr still holds the HALT's own PC here
                if (int_req && !int_active) begin
                    epc_n         = redir_addr + ADDR_W'(1);
                    int_active_n  = 1'b1;
                    halted_n      = 1'b0;
                    redir_addr_n  = INT_VECTOR;
                    redir_valid_n = 1'b1;
                    flush_n       = 1'b1;
                    state_n       = ST_PEND;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        reset, ex_valid, jump_valid, ex_halt, ex_reti, int_req, redir_ready;
    logic [31:0] jump_addr, ex_next_pc;
    logic        redir_valid, flush, ex_stall, halted, int_active;
    logic [31:0] redir_addr, epc, redirect_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: at most one outstanding redirect target plus a parked flag
    logic [31:0] pend_q[$];
    bit          m_parked, m_halt_after, m_ia;
    logic [31:0] m_halt_pc, m_epc, m_count;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.ADDR_W(32), .INT_VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .jump_valid(jump_valid),
        .jump_addr(jump_addr), .ex_halt(ex_halt), .ex_reti(ex_reti),
        .ex_next_pc(ex_next_pc), .int_req(int_req), .redir_ready(redir_ready),
        .redir_valid(redir_valid), .redir_addr(redir_addr), .flush(flush),
        .ex_stall(ex_stall), .halted(halted), .int_active(int_active),
        .epc(epc), .redirect_count(redirect_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            pend_q.delete();
            m_parked = 0; m_halt_after = 0; m_ia = 0;
            m_halt_pc = '0; m_epc = '0; m_count = '0;
        end else if (pend_q.size() != 0) begin
            if (redir_ready) begin
                m_count = m_count + 1;
                if (m_halt_after) begin
                    m_parked  = 1;
                    m_halt_pc = pend_q[0];
                end
                m_halt_after = 0;
                pend_q.delete();
            end
        end else if (m_parked) begin
            if (int_req && !m_ia) begin
                m_epc    = m_halt_pc + 1;
                m_ia     = 1;
                m_parked = 0;
                pend_q.push_back(VEC);
            end
        end else if (ex_valid && ex_reti) begin
            pend_q.push_back(m_epc);
            m_ia = 0;
        end else if (ex_valid && jump_valid) begin
            pend_q.push_back(jump_addr);
            m_halt_after = ex_halt;
        end else if (int_req && !m_ia) begin
            m_epc = ex_next_pc;
            m_ia  = 1;
            pend_q.push_back(VEC);
        end
    endtask

    task automatic compare_all();
        bit busy;
        busy = (pend_q.size() != 0);
        check_eq("redir_valid", 32'(redir_valid), 32'(busy));
        check_eq("flush", 32'(flush), 32'(busy || m_parked));
        check_eq("ex_stall", 32'(ex_stall), 32'(busy || m_parked));
        check_eq("halted", 32'(halted), 32'(m_parked));
        check_eq("int_active", 32'(int_active), 32'(m_ia));
        check_eq("epc", epc, m_epc);
        check_eq("redirect_count", redirect_count, m_count);
        if (busy) check_eq("redir_addr", redir_addr, pend_q[0]);
    endtask

    // Inputs are stable across the edge; outputs are sampled 1ns after it
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        ex_valid = 0; jump_valid = 0; ex_halt = 0; ex_reti = 0; int_req = 0;
        redir_ready = rdy;
    endtask

    initial begin
        reset = 1; idle(1'b1);
        ex_valid = 1; jump_valid = 1; jump_addr = 32'h0000_0ABC; ex_next_pc = '0;
        cycle(); cycle();
        check_eq("reset_count", redirect_count, 32'd0);
        check_eq("reset_valid", 32'(redir_valid), 32'd0);
        reset = 0; idle(1'b1);
        cycle();
        check_eq("post_reset_stall", 32'(ex_stall), 32'd0);

        // Jump with ready already high
        ex_valid = 1; jump_valid = 1; jump_addr = 32'h100;
        cycle();
        check_eq("j100_addr", redir_addr, 32'h100);
        check_eq("j100_flush", 32'(flush), 32'd1);
        idle(1'b1);
        cycle();
        check_eq("j100_done", 32'(redir_valid), 32'd0);
        check_eq("j100_count", redirect_count, 32'd1);

        // Jump held off by fetch for three cycles
        ex_valid = 1; jump_valid = 1; jump_addr = 32'h200; redir_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            idle(1'b0);
            check_eq("j200_hold_addr", redir_addr, 32'h200);
            check_eq("j200_hold_stall", 32'(ex_stall), 32'd1);
        end
        redir_ready = 1;
        cycle();
        check_eq("j200_count", redirect_count, 32'd2);

        // Interrupt with no EX instruction, then RETI
        int_req = 1; ex_next_pc = 32'h50;
        cycle();
        check_eq("int_epc", epc, 32'h50);
        check_eq("int_addr", redir_addr, VEC);
        idle(1'b1);
        cycle();
        ex_valid = 1; ex_reti = 1;
        cycle();
        check_eq("reti_addr", redir_addr, 32'h50);
        check_eq("reti_ia", 32'(int_active), 32'd0);
        idle(1'b1);
        cycle();

        // HALT, then wake on interrupt
        ex_valid = 1; jump_valid = 1; ex_halt = 1; jump_addr = 32'h30;
        cycle();
        idle(1'b1);
        cycle();
        check_eq("halt_halted", 32'(halted), 32'd1);
        check_eq("halt_flush", 32'(flush), 32'd1);
        cycle();
        int_req = 1;
        cycle();
        check_eq("wake_epc", epc, 32'h31);
        check_eq("wake_addr", redir_addr, VEC);
        check_eq("wake_halted", 32'(halted), 32'd0);
        idle(1'b1);
        cycle();
        ex_valid = 1; ex_reti = 1;
        cycle();
        idle(1'b1);
        cycle();

        // Jump and interrupt together: jump first, interrupt right after
        ex_valid = 1; jump_valid = 1; jump_addr = 32'h80; int_req = 1; ex_next_pc = 32'h90;
        cycle();
        check_eq("jint_addr", redir_addr, 32'h80);
        ex_valid = 0; jump_valid = 0;
        cycle();
        check_eq("jint_hs", 32'(redir_valid), 32'd0);
        cycle();
        check_eq("jint_int_addr", redir_addr, VEC);
        check_eq("jint_epc", epc, 32'h90);
        idle(1'b1);
        cycle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            jump_valid  = ($urandom_range(0, 2) == 0);
            ex_halt     = jump_valid && ($urandom_range(0, 9) == 0);
            ex_reti     = ($urandom_range(0, 9) == 0);
            int_req     = ($urandom_range(0, 4) == 0);
            redir_ready = ($urandom_range(0, 2) != 0);
            jump_addr   = $urandom;
            ex_next_pc  = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
